// File: rtl/vga_seq_pkg.sv
// rtl/vga_seq_pkg.sv - shared register indices, reset values and reset FSM encoding
package vga_seq_pkg;

  localparam logic [2:0] SR_RESET = 3'd0;
  localparam logic [2:0] SR_CLOCK = 3'd1;
  localparam logic [2:0] SR_MAPMASK = 3'd2;
  localparam logic [2:0] SR_CHARMAP = 3'd3;
  localparam logic [2:0] SR_MEMMODE = 3'd4;

  localparam logic [7:0] SR0_RST = 8'h03;
  localparam logic [7:0] SR1_RST = 8'h00;
  localparam logic [7:0] SR2_RST = 8'h0F;
  localparam logic [7:0] SR3_RST = 8'h00;
  localparam logic [7:0] SR4_RST = 8'h00;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SOFT = 2'd1,
    ST_HARD = 2'd2
  } seq_state_e;

  function automatic logic [7:0] hold_dec(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
  endfunction

endpackage

// File: rtl/seq_reset_fsm.sv
// rtl/seq_reset_fsm.sv - sequencer reset episode FSM with minimum hold counter
module seq_reset_fsm
  import vga_seq_pkg::*;
#(
  parameter int unsigned RESET_HOLD = 8
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       async_run_i,
  input  logic       sync_run_i,
  output seq_state_e state_o,
  output logic       hardreset_o,
  output logic       softreset_o
);

  localparam logic [7:0] HOLD_LOAD = 8'(RESET_HOLD);

  logic [7:0] cnt_q;
  logic       hold_done;

  // The exit edge is the one that takes the counter to 0, so an episode lasts RESET_HOLD cycles.
  assign hold_done = (cnt_q <= 8'd1);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_o     <= ST_RUN;
      cnt_q       <= 8'd0;
      hardreset_o <= 1'b0;
      softreset_o <= 1'b0;
    end else if (!async_run_i) begin
      if (state_o != ST_HARD) begin
        cnt_q <= HOLD_LOAD;
      end else begin
        cnt_q <= hold_dec(cnt_q);
      end
      state_o     <= ST_HARD;
      hardreset_o <= 1'b1;
      softreset_o <= 1'b1;
    end else begin
      case (state_o)
        ST_RUN: begin
          if (!sync_run_i) begin
            state_o     <= ST_SOFT;
            cnt_q       <= HOLD_LOAD;
            hardreset_o <= 1'b0;
            softreset_o <= 1'b1;
          end
        end
        ST_HARD: begin
          if (hold_done) begin
            state_o     <= ST_SOFT;
            cnt_q       <= HOLD_LOAD;
            hardreset_o <= 1'b0;
            softreset_o <= 1'b1;
          end else begin
            cnt_q <= hold_dec(cnt_q);
          end
        end
        ST_SOFT: begin
          cnt_q <= hold_dec(cnt_q);
          if (sync_run_i && hold_done) begin
            state_o     <= ST_RUN;
            hardreset_o <= 1'b0;
            softreset_o <= 1'b0;
          end
        end
        default: begin
          state_o     <= ST_RUN;
          cnt_q       <= 8'd0;
          hardreset_o <= 1'b0;
          softreset_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_reg_ctrl.sv
// rtl/seq_reg_ctrl.sv - VGA sequencer register file with staged clocking-mode bits
module seq_reg_ctrl
  import vga_seq_pkg::*;
#(
  parameter int unsigned RESET_HOLD = 8
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       bus_sel_i,
  input  logic       bus_we_i,
  input  logic       bus_addr_i,
  input  logic [7:0] bus_dat_i,
  output logic [7:0] bus_dat_o,
  output logic       bus_ack_o,
  input  logic       vblank_i,
  output logic       hardreset_o,
  output logic       softreset_o,
  output logic       chrwidth8_o,
  output logic       divclkby2_o,
  output logic       vgainhibit_o,
  output logic [3:0] mapmask_o,
  output logic [2:0] fontAoff_o,
  output logic [2:0] fontBoff_o,
  output logic       fontselect_o,
  output logic       textmodemem_o,
  output logic       packedpixel_o
);

  logic [2:0] index_q;
  logic [7:0] sr0_q, sr1_q, sr2_q, sr3_q, sr4_q;
  logic       pending_q, chrwidth8_q, divclkby2_q;
  logic       vblank_d, apply_pulse_q, apply;
  logic       wr_en;
  logic [7:0] rdata;
  seq_state_e state;

  seq_reset_fsm #(.RESET_HOLD(RESET_HOLD)) u_reset_fsm (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .async_run_i (sr0_q[0]),
    .sync_run_i  (sr0_q[1]),
    .state_o     (state),
    .hardreset_o (hardreset_o),
    .softreset_o (softreset_o)
  );

  assign wr_en = bus_sel_i & bus_we_i;
  assign apply = apply_pulse_q | (state != ST_RUN);

  always_comb begin
    rdata = 8'h00;
    if (!bus_addr_i) begin
      rdata = {5'b0, index_q};
    end else begin
      case (index_q)
        SR_RESET:   rdata = sr0_q;
        SR_CLOCK:   rdata = sr1_q;
        SR_MAPMASK: rdata = sr2_q;
        SR_CHARMAP: rdata = sr3_q;
        SR_MEMMODE: rdata = sr4_q;
        default:    rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      index_q       <= 3'd0;
      sr0_q         <= SR0_RST;
      sr1_q         <= SR1_RST;
      sr2_q         <= SR2_RST;
      sr3_q         <= SR3_RST;
      sr4_q         <= SR4_RST;
      pending_q     <= 1'b0;
      chrwidth8_q   <= 1'b0;
      divclkby2_q   <= 1'b0;
      vblank_d      <= 1'b0;
      apply_pulse_q <= 1'b0;
      bus_ack_o     <= 1'b0;
      bus_dat_o     <= 8'h00;
    end else begin
      bus_ack_o     <= bus_sel_i;
      bus_dat_o     <= (bus_sel_i && !bus_we_i) ? rdata : 8'h00;
      vblank_d      <= vblank_i;
      apply_pulse_q <= vblank_i & ~vblank_d;
      // Applies the pre-write shadow; a coincident SR1 write re-arms pending below.
      if (apply && pending_q) begin
        chrwidth8_q <= sr1_q[0];
        divclkby2_q <= sr1_q[3];
        pending_q   <= 1'b0;
      end
      if (wr_en) begin
        if (!bus_addr_i) begin
          index_q <= bus_dat_i[2:0];
        end else begin
          case (index_q)
            SR_RESET:   sr0_q <= bus_dat_i;
            SR_CLOCK: begin
              sr1_q     <= bus_dat_i;
              pending_q <= 1'b1;
            end
            SR_MAPMASK: sr2_q <= bus_dat_i;
            SR_CHARMAP: sr3_q <= bus_dat_i;
            SR_MEMMODE: sr4_q <= bus_dat_i;
            default: ;
          endcase
        end
      end
    end
  end

  assign chrwidth8_o   = chrwidth8_q;
  assign divclkby2_o   = divclkby2_q;
  assign vgainhibit_o  = sr1_q[5];
  assign mapmask_o     = sr2_q[3:0];
  assign fontAoff_o    = {sr3_q[5], sr3_q[3:2]};
  assign fontBoff_o    = {sr3_q[4], sr3_q[1:0]};
  assign fontselect_o  = (fontAoff_o != fontBoff_o);
  assign textmodemem_o = sr4_q[2];
  assign packedpixel_o = sr4_q[3];

endmodule

// File: tb/tb_seq_reg_ctrl.sv
// tb/tb_seq_reg_ctrl.sv - directed self-checking bench for seq_reg_ctrl
module tb_seq_reg_ctrl;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       bus_sel_i = 1'b0;
  logic       bus_we_i = 1'b0;
  logic       bus_addr_i = 1'b0;
  logic [7:0] bus_dat_i = 8'h00;
  logic [7:0] bus_dat_o;
  logic       bus_ack_o;
  logic       vblank_i = 1'b0;
  logic       hardreset_o, softreset_o;
  logic       chrwidth8_o, divclkby2_o, vgainhibit_o;
  logic [3:0] mapmask_o;
  logic [2:0] fontAoff_o, fontBoff_o;
  logic       fontselect_o, textmodemem_o, packedpixel_o;

  int checks = 0;
  int errors = 0;

  seq_reg_ctrl #(.RESET_HOLD(8)) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .bus_sel_i     (bus_sel_i),
    .bus_we_i      (bus_we_i),
    .bus_addr_i    (bus_addr_i),
    .bus_dat_i     (bus_dat_i),
    .bus_dat_o     (bus_dat_o),
    .bus_ack_o     (bus_ack_o),
    .vblank_i      (vblank_i),
    .hardreset_o   (hardreset_o),
    .softreset_o   (softreset_o),
    .chrwidth8_o   (chrwidth8_o),
    .divclkby2_o   (divclkby2_o),
    .vgainhibit_o  (vgainhibit_o),
    .mapmask_o     (mapmask_o),
    .fontAoff_o    (fontAoff_o),
    .fontBoff_o    (fontBoff_o),
    .fontselect_o  (fontselect_o),
    .textmodemem_o (textmodemem_o),
    .packedpixel_o (packedpixel_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic wr(input logic addr, input logic [7:0] data);
    @(negedge clock_i);
    bus_sel_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = addr; bus_dat_i = data;
    @(negedge clock_i);
    bus_sel_i = 1'b0; bus_we_i = 1'b0;
  endtask

  task automatic rd(input logic addr, output logic ack, output logic [7:0] data);
    @(negedge clock_i);
    bus_sel_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = addr;
    @(negedge clock_i);
    ack = bus_ack_o; data = bus_dat_o;
    bus_sel_i = 1'b0;
  endtask

  task automatic pulse_vblank();
    @(negedge clock_i); vblank_i = 1'b1;
    @(negedge clock_i); vblank_i = 1'b0;
    @(negedge clock_i);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(negedge clock_i);
    checks++;
    if ({hardreset_o, softreset_o, chrwidth8_o, divclkby2_o, vgainhibit_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {hardreset_o, softreset_o, chrwidth8_o, divclkby2_o, vgainhibit_o});
    end
    checks++;
    if ({mapmask_o, fontAoff_o, fontBoff_o, fontselect_o, textmodemem_o, packedpixel_o} !== {4'hF, 9'b0}) begin
      errors++; $display("FAIL reset_mem got %h/%0d/%0d/%b%b%b want f/0/0/000", mapmask_o, fontAoff_o, fontBoff_o, fontselect_o, textmodemem_o, packedpixel_o);
    end
    checks++;
    if ({bus_ack_o, bus_dat_o} !== 9'h000) begin
      errors++; $display("FAIL reset_bus got ack=%b dat=%h want 0/00", bus_ack_o, bus_dat_o);
    end
    reset_i = 1'b0;
    @(negedge clock_i);
  endtask

  task automatic test_read_defaults();
    logic ack; logic [7:0] d;
    wr(1'b0, 8'd2);
    rd(1'b1, ack, d);
    checks++;
    if (ack !== 1'b1 || d !== 8'h0F) begin errors++; $display("FAIL rd_sr2 got ack=%b dat=%h want 1/0f", ack, d); end
    @(negedge clock_i);
    checks++;
    if (bus_ack_o !== 1'b0) begin errors++; $display("FAIL ack_single got %b want 0", bus_ack_o); end
    wr(1'b0, 8'd6);
    wr(1'b1, 8'hFF);
    rd(1'b1, ack, d);
    checks++;
    if (ack !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL rd_idx6 got ack=%b dat=%h want 1/00", ack, d); end
    rd(1'b0, ack, d);
    checks++;
    if (d !== 8'h06) begin errors++; $display("FAIL rd_index got %h want 06", d); end
  endtask

  task automatic test_softreset();
    int soft_n = 0; int hard_n = 0;
    wr(1'b0, 8'd0);
    wr(1'b1, 8'h01);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock_i);
      if (softreset_o) soft_n++;
      if (hardreset_o) hard_n++;
      if (i == 1) begin bus_sel_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = 1'b1; bus_dat_i = 8'h03; end
      if (i == 2) begin bus_sel_i = 1'b0; bus_we_i = 1'b0; end
    end
    checks++;
    if (soft_n !== 8) begin errors++; $display("FAIL soft_len got %0d want 8", soft_n); end
    checks++;
    if (hard_n !== 0) begin errors++; $display("FAIL soft_nohard got %0d want 0", hard_n); end
  endtask

  task automatic test_hardreset();
    int hard_n = 0; int soft_during_hard = 0; int soft_only = 0; int hard_late = 0;
    wr(1'b1, 8'h02);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_i);
      if (hardreset_o) hard_n++;
      if (hardreset_o && softreset_o) soft_during_hard++;
    end
    wr(1'b1, 8'h03);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock_i);
      if (softreset_o && !hardreset_o) soft_only++;
      if (hardreset_o) hard_late++;
    end
    checks++;
    if (hard_n < 8 || soft_during_hard != hard_n) begin
      errors++; $display("FAIL hard_len got %0d (soft %0d) want >=8 with soft", hard_n, soft_during_hard);
    end
    checks++;
    if (soft_only !== 8 || hard_late !== 0) begin
      errors++; $display("FAIL hard_then_soft got soft=%0d hard=%0d want 8/0", soft_only, hard_late);
    end
    checks++;
    if (softreset_o !== 1'b0) begin errors++; $display("FAIL hard_run got soft=%b want 0", softreset_o); end
  endtask

  task automatic test_staged();
    logic ack; logic [7:0] d;
    wr(1'b0, 8'd1);
    wr(1'b1, 8'h09);
    repeat (3) @(negedge clock_i);
    checks++;
    if ({chrwidth8_o, divclkby2_o} !== 2'b00) begin errors++; $display("FAIL staged_hold got %b want 00", {chrwidth8_o, divclkby2_o}); end
    rd(1'b1, ack, d);
    checks++;
    if (d !== 8'h09) begin errors++; $display("FAIL sr1_shadow got %h want 09", d); end
    pulse_vblank();
    checks++;
    if ({chrwidth8_o, divclkby2_o} !== 2'b11) begin errors++; $display("FAIL staged_apply got %b want 11", {chrwidth8_o, divclkby2_o}); end
  endtask

  task automatic test_coincident();
    logic ack; logic [7:0] d;
    wr(1'b1, 8'h01);
    @(negedge clock_i); vblank_i = 1'b1;
    @(negedge clock_i); vblank_i = 1'b0;
    bus_sel_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = 1'b1; bus_dat_i = 8'h08;
    @(negedge clock_i); bus_sel_i = 1'b0; bus_we_i = 1'b0;
    repeat (4) @(negedge clock_i);
    checks++;
    if ({chrwidth8_o, divclkby2_o} !== 2'b10) begin errors++; $display("FAIL coinc_old got %b want 10", {chrwidth8_o, divclkby2_o}); end
    rd(1'b1, ack, d);
    checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL coinc_shadow got %h want 08", d); end
    pulse_vblank();
    checks++;
    if ({chrwidth8_o, divclkby2_o} !== 2'b01) begin errors++; $display("FAIL coinc_new got %b want 01", {chrwidth8_o, divclkby2_o}); end
    wr(1'b1, 8'h28);
    checks++;
    if (vgainhibit_o !== 1'b1) begin errors++; $display("FAIL vgainhibit got %b want 1", vgainhibit_o); end
  endtask

  task automatic test_mapping();
    logic [7:0] vec [4] = '{8'h2C, 8'h15, 8'h12, 8'h3F};
    logic [6:0] exp [4] = '{{3'd7, 3'd0, 1'b1}, {3'd1, 3'd5, 1'b1}, {3'd0, 3'd6, 1'b1}, {3'd7, 3'd7, 1'b0}};
    wr(1'b0, 8'd3);
    for (int i = 0; i < 4; i++) begin
      wr(1'b1, vec[i]);
      checks++;
      if ({fontAoff_o, fontBoff_o, fontselect_o} !== exp[i]) begin
        errors++; $display("FAIL font_%h got A=%0d B=%0d sel=%b want %b", vec[i], fontAoff_o, fontBoff_o, fontselect_o, exp[i]);
      end
    end
    wr(1'b0, 8'd2);
    wr(1'b1, 8'hA5);
    checks++;
    if (mapmask_o !== 4'h5) begin errors++; $display("FAIL mapmask got %h want 5", mapmask_o); end
    wr(1'b0, 8'd4);
    wr(1'b1, 8'h0C);
    checks++;
    if ({textmodemem_o, packedpixel_o} !== 2'b11) begin errors++; $display("FAIL memmode got %b want 11", {textmodemem_o, packedpixel_o}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clock_i);
    bus_sel_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 1'b0;
    @(negedge clock_i);
    checks++;
    if (bus_ack_o !== 1'b1 || bus_dat_o !== 8'h04) begin errors++; $display("FAIL b2b_first got ack=%b dat=%h want 1/04", bus_ack_o, bus_dat_o); end
    bus_addr_i = 1'b1;
    @(negedge clock_i);
    checks++;
    if (bus_ack_o !== 1'b1 || bus_dat_o !== 8'h0C) begin errors++; $display("FAIL b2b_second got ack=%b dat=%h want 1/0c", bus_ack_o, bus_dat_o); end
    bus_sel_i = 1'b0;
    @(negedge clock_i);
    checks++;
    if (bus_ack_o !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", bus_ack_o); end
  endtask

  task automatic test_reset_abort();
    logic ack; logic [7:0] d;
    wr(1'b0, 8'd0);
    wr(1'b1, 8'h01);
    repeat (3) @(negedge clock_i);
    checks++;
    if (softreset_o !== 1'b1) begin errors++; $display("FAIL abort_pre got %b want 1", softreset_o); end
    bus_sel_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 1'b1;
    reset_i = 1'b1;
    @(negedge clock_i);
    checks++;
    if ({bus_ack_o, softreset_o, hardreset_o} !== 3'b000) begin
      errors++; $display("FAIL abort_rst got ack=%b soft=%b hard=%b want 000", bus_ack_o, softreset_o, hardreset_o);
    end
    bus_sel_i = 1'b0;
    reset_i = 1'b0;
    repeat (3) @(negedge clock_i);
    rd(1'b1, ack, d);
    checks++;
    if (softreset_o !== 1'b0 || d !== 8'h03 || mapmask_o !== 4'hF) begin
      errors++; $display("FAIL abort_post got soft=%b sr0=%h mask=%h want 0/03/f", softreset_o, d, mapmask_o);
    end
  endtask

  initial begin
    test_reset();
    test_read_defaults();
    test_softreset();
    test_hardreset();
    test_staged();
    test_coincident();
    test_mapping();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
